// File: rtl/shared_adder_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters, one response consumer and the
// shared adder. The master side is the requesters plus the consumer. The slave
// side is the arbiter/adder block.
interface shared_adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_operand_a;
  logic [NUM_REQ*WIDTH-1:0] req_operand_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH:0]           rsp_sum;

  modport master (
    output req_valid, req_operand_a, req_operand_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/shared_adder_arbiter.sv
// One registered WIDTH-bit adder shared round-robin between NUM_REQ requesters.
// The block runs one transaction at a time: accept (IDLE), add (COMPUTE), then
// hold the tagged result until the consumer takes it (RESPOND).
module shared_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  shared_adder_arbiter_if.slave         bus,
  output logic                          busy,
  output logic [CNT_W-1:0]              op_count
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESPOND
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   grant_next;
  logic [WIDTH-1:0]  grant_a;
  logic [WIDTH-1:0]  grant_b;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_a     = '0;
    grant_b     = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
        grant_a     = bus.req_operand_a[idx*WIDTH +: WIDTH];
        grant_b     = bus.req_operand_b[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves just past the winner; collapses to constant 0 when NUM_REQ=1.
  always_comb begin
    grant_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Ready is offered only in IDLE, only to the winner, and never during reset.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !reset && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Busy whenever a transaction is in flight.
  always_comb begin
    busy = (state != IDLE);
  end

  // Transaction FSM: capture, add, hold response until consumed.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_sum   <= '0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            a_q    <= grant_a;
            b_q    <= grant_b;
            id_q   <= grant_idx;
            rr_ptr <= grant_next;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          bus.rsp_sum   <= {1'b0, a_q} + {1'b0, b_q};
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
          state         <= RESPOND;
        end
        RESPOND: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            op_count      <= op_count + CNT_W'(1);
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter (NUM_REQ=4, WIDTH=8). Expected sums,
// ids and counts are hand-computed constants.
module tb_shared_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             reset;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int passed  = 0;
  int total   = 0;
  int exp_cnt = 0;

  shared_adder_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  shared_adder_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .busy    (busy),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_operand_a[i*WIDTH +: WIDTH] = a;
    bus.req_operand_b[i*WIDTH +: WIDTH] = b;
  endtask

  // One full transaction with rsp_ready=1: grant, compute, respond, back to IDLE.
  task automatic run_one(input int id, input logic [8:0] sum);
    #1;
    check("grant", 32'(bus.req_ready), 32'(1 << id));
    step();
    check("compute", 32'({busy, bus.rsp_valid, bus.req_ready}), 32'({1'b1, 1'b0, 4'b0000}));
    step();
    check("respond", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum}), 32'({1'b1, 2'(id), sum}));
    check("respond_ready", 32'(bus.req_ready), 32'(0));
    exp_cnt++;
    step();
    check("done", 32'({bus.rsp_valid, busy, op_count}), 32'({1'b0, 1'b0, 16'(exp_cnt)}));
  endtask

  initial begin
    reset             = 1'b1;
    bus.req_valid     = '0;
    bus.req_operand_a = '0;
    bus.req_operand_b = '0;
    bus.rsp_ready     = 1'b0;

    // Reset: ready held low even with requests present
    step();
    bus.req_valid = 4'b1111;
    #1;
    check("ready_in_reset", 32'(bus.req_ready), 32'(0));
    step();
    reset         = 1'b0;
    bus.req_valid = '0;
    #1;
    check("reset_state", 32'({bus.rsp_valid, busy, bus.rsp_id, bus.rsp_sum, op_count}), 32'(0));

    // Single requester 2: 12+34 = 046, response two cycles after accept
    set_ops(2, 8'h12, 8'h34);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    check("t1_grant", 32'(bus.req_ready), 32'(4'b0100));
    step();
    bus.req_valid = '0;
    check("t1_compute", 32'({busy, bus.rsp_valid}), 32'({1'b1, 1'b0}));
    step();
    check("t1_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum}), 32'({1'b1, 2'd2, 9'h046}));
    exp_cnt++;
    step();
    check("t1_count", 32'({bus.rsp_valid, busy, op_count}), 32'({1'b0, 1'b0, 16'd1}));

    // Fairness after skip: pointer is 3, valid=0011 grants 0 then 1
    set_ops(0, 8'h05, 8'h06);
    set_ops(1, 8'h0A, 8'h0B);
    bus.req_valid = 4'b0011;
    run_one(0, 9'h00B);
    run_one(1, 9'h015);

    // Carry-out cases on requester 0
    bus.req_valid = 4'b0001;
    set_ops(0, 8'hFF, 8'hFF);
    run_one(0, 9'h1FE);
    set_ops(0, 8'h80, 8'h80);
    run_one(0, 9'h100);

    // Backpressure on requester 1: 33+44 = 077 held for 10 cycles
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    set_ops(1, 8'h33, 8'h44);
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'(4'b0010));
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.req_ready, busy}),
            32'({1'b1, 2'd1, 9'h077, 4'b0000, 1'b1}));
      step();
    end
    bus.rsp_ready = 1'b1;
    exp_cnt++;
    step();
    check("bp_release", 32'({bus.rsp_valid, busy, op_count}), 32'({1'b0, 1'b0, 16'(exp_cnt)}));
    check("bp_next_grant", 32'(bus.req_ready), 32'(4'b0010));
    // Requester 1 withdraws before being granted: nothing is accepted
    bus.req_valid = '0;
    step();
    check("withdraw_idle", 32'({busy, bus.rsp_valid}), 32'(0));

    // Re-reset, then all requesters valid: rotation 0,1,2,3,0
    reset = 1'b1;
    step();
    reset   = 1'b0;
    exp_cnt = 0;
    check("rereset_count", 32'(op_count), 32'(0));
    set_ops(0, 8'h01, 8'h02);
    set_ops(1, 8'h10, 8'h20);
    set_ops(2, 8'h7F, 8'h01);
    set_ops(3, 8'hF0, 8'h0F);
    bus.req_valid = 4'b1111;
    run_one(0, 9'h003);
    run_one(1, 9'h030);
    run_one(2, 9'h080);
    run_one(3, 9'h0FF);
    run_one(0, 9'h003);

    // Reset during RESPOND discards the transaction
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = '0;
    step();
    check("mid_respond", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum}), 32'({1'b1, 2'd2, 9'h080}));
    reset = 1'b1;
    step();
    check("mid_reset", 32'({bus.rsp_valid, busy, bus.rsp_id, bus.rsp_sum, op_count}), 32'(0));
    reset         = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("no_stale", 32'({bus.rsp_valid, busy}), 32'(0));
    end
    bus.req_valid = 4'b1111;
    #1;
    check("ptr_reset", 32'(bus.req_ready), 32'(4'b0001));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
